// File: rtl/nonce_result_arbiter.sv
// Round-robin arbiter serialising per-core found-nonce results into the nonce_buffer write port.
// Optional NONCE_ARB_TAG_EN adds core_id_o carrying the granted core index alongside nonce_o.
module nonce_result_arbiter #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned NONCE_W    = 32,
   parameter int unsigned DROP_CNT_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CORES-1:0]           core_valid,
   input  logic [NUM_CORES-1:0]           core_success,
   input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
   input  logic                           buf_full,
   output logic                           valid,
   output logic                           success,
   output logic [NONCE_W-1:0]             nonce_o,
   output logic [NUM_CORES-1:0]           pending,
   output logic [DROP_CNT_W-1:0]          drop_cnt,
   output logic                           drop_flag
`ifdef NONCE_ARB_TAG_EN
   ,
   output logic [$clog2(NUM_CORES)-1:0]   core_id_o
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_CORES);
   localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);
   localparam int unsigned SUM_W = ((DROP_CNT_W > CNT_W) ? DROP_CNT_W : CNT_W) + 1;
   localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_CNT_W{1'b1}});

   logic [NONCE_W-1:0]    slot_q [NUM_CORES];
   logic [NONCE_W-1:0]    slot_d [NUM_CORES];
   logic [NUM_CORES-1:0]  pending_q, pending_d;
   logic [IDX_W-1:0]      rr_q, rr_d;
   logic                  valid_q, valid_d;
   logic                  success_q, success_d;
   logic [NONCE_W-1:0]    nonce_q, nonce_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic                  drop_flag_q, drop_flag_d;

   logic                  gnt_vld;
   logic [IDX_W-1:0]      gnt_idx;
   logic [CNT_W-1:0]      ndrop;
   logic [SUM_W-1:0]      drop_sum;

   // First pending slot at or after the rr pointer, with wrap; suppressed while the buffer is full.
   always_comb begin
      int unsigned idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned off = 0; off < NUM_CORES; off++) begin
         idx = (32'(rr_q) + off) % NUM_CORES;
         if (!gnt_vld && pending_q[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(idx);
         end
      end
      if (buf_full) begin
         gnt_vld = 1'b0;
      end
   end

   always_comb begin
      slot_d      = slot_q;
      pending_d   = pending_q;
      rr_d        = rr_q;
      valid_d     = 1'b0;
      success_d   = 1'b0;
      nonce_d     = nonce_q;
      ndrop       = '0;
      drop_sum    = '0;
      drop_cnt_d  = drop_cnt_q;
      drop_flag_d = drop_flag_q;

      if (gnt_vld) begin
         valid_d            = 1'b1;
         success_d          = 1'b1;
         nonce_d            = slot_q[gnt_idx];
         pending_d[gnt_idx] = 1'b0;
         rr_d               = (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
      end

      // A slot being granted this cycle frees up in time to take a new capture.
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (core_valid[i] && core_success[i]) begin
            if (pending_q[i] && !(gnt_vld && gnt_idx == IDX_W'(i))) begin
               ndrop = ndrop + 1'b1;
            end else begin
               slot_d[i]    = core_nonce[i*NONCE_W +: NONCE_W];
               pending_d[i] = 1'b1;
            end
         end
      end

      drop_sum    = SUM_W'(drop_cnt_q) + SUM_W'(ndrop);
      drop_cnt_d  = (drop_sum > DROP_MAX) ? '1 : DROP_CNT_W'(drop_sum);
      drop_flag_d = drop_flag_q | (ndrop != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            slot_q[i] <= '0;
         end
         pending_q   <= '0;
         rr_q        <= '0;
         valid_q     <= 1'b0;
         success_q   <= 1'b0;
         nonce_q     <= '0;
         drop_cnt_q  <= '0;
         drop_flag_q <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         pending_q   <= pending_d;
         rr_q        <= rr_d;
         valid_q     <= valid_d;
         success_q   <= success_d;
         nonce_q     <= nonce_d;
         drop_cnt_q  <= drop_cnt_d;
         drop_flag_q <= drop_flag_d;
      end
   end

`ifdef NONCE_ARB_TAG_EN
   logic [IDX_W-1:0] core_id_q, core_id_d;

   always_comb begin
      core_id_d = core_id_q;
      if (gnt_vld) begin
         core_id_d = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         core_id_q <= '0;
      end else begin
         core_id_q <= core_id_d;
      end
   end

   assign core_id_o = core_id_q;
`endif

   assign valid     = valid_q;
   assign success   = success_q;
   assign nonce_o   = nonce_q;
   assign pending   = pending_q;
   assign drop_cnt  = drop_cnt_q;
   assign drop_flag = drop_flag_q;

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Self-checking bench for nonce_result_arbiter: directed vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_nonce_result_arbiter;

   localparam int unsigned NC = 4;
   localparam int unsigned NW = 32;
   localparam int unsigned DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC-1:0]   core_valid;
   logic [NC-1:0]   core_success;
   logic [NC*NW-1:0] core_nonce;
   logic            buf_full;
   logic            valid;
   logic            success;
   logic [NW-1:0]   nonce_o;
   logic [NC-1:0]   pending;
   logic [DW-1:0]   drop_cnt;
   logic            drop_flag;
`ifdef NONCE_ARB_TAG_EN
   logic [1:0]      core_id_o;
`endif

   int checks   = 0;
   int failures = 0;

   nonce_result_arbiter #(.NUM_CORES(NC), .NONCE_W(NW), .DROP_CNT_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .core_valid   (core_valid),
      .core_success (core_success),
      .core_nonce   (core_nonce),
      .buf_full     (buf_full),
      .valid        (valid),
      .success      (success),
      .nonce_o      (nonce_o),
      .pending      (pending),
      .drop_cnt     (drop_cnt),
      .drop_flag    (drop_flag)
`ifdef NONCE_ARB_TAG_EN
      ,
      .core_id_o    (core_id_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   cv;
      logic [3:0]   cs;
      logic [127:0] cn;
      logic         bf;
      logic         ev;
      logic [31:0]  en;
      logic [3:0]   ep;
      logic [7:0]   ed;
      logic         ef;
   } vec_t;

   function automatic logic [127:0] one(input int core, input logic [31:0] val);
      logic [127:0] r;
      r = '0;
      r[core*32 +: 32] = val;
      return r;
   endfunction

   function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic vec_t mk(input logic [3:0] cv, cs, input int core, input logic [31:0] val,
                               input logic bf, ev, input logic [31:0] en, input logic [3:0] ep,
                               input logic [7:0] ed, input logic ef);
      vec_t v;
      v.cv = cv; v.cs = cs; v.cn = one(core, val); v.bf = bf;
      v.ev = ev; v.en = en; v.ep = ep; v.ed = ed; v.ef = ef;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the edge.
   task automatic step(input logic [3:0] cv, cs, input logic [127:0] cn, input logic bf);
      core_valid   = cv;
      core_success = cs;
      core_nonce   = cn;
      buf_full     = bf;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic bf);
      step(4'b0, 4'b0, '0, bf);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1'b0);
      idle(1'b0);
      rst = 1'b0;
   endtask

   // Reference model state
   int          m_rr;
   logic [31:0] m_slot [4];
   bit          m_pend [4];
   bit          m_valid;
   logic [31:0] m_nonce;
   int          m_drop;
   bit          m_flag;

   task automatic model_reset();
      m_rr = 0; m_valid = 0; m_nonce = '0; m_drop = 0; m_flag = 0;
      for (int i = 0; i < 4; i++) begin
         m_slot[i] = '0;
         m_pend[i] = 0;
      end
   endtask

   task automatic model_cycle(input logic [3:0] cv, cs, input logic [127:0] cn, input logic bf);
      int g;
      int drops;
      g = -1;
      drops = 0;
      if (!bf) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
         end
      end
      if (g >= 0) begin
         m_valid = 1;
         m_nonce = m_slot[g];
         m_rr    = (g + 1) % 4;
      end else begin
         m_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
         bit was_pend;
         was_pend = m_pend[i] && (i != g);
         if (i == g) m_pend[i] = 0;
         if (cv[i] && cs[i]) begin
            if (was_pend) begin
               drops++;
            end else begin
               m_slot[i] = cn[i*32 +: 32];
               m_pend[i] = 1;
            end
         end
      end
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      if (drops > 0) m_flag = 1;
   endtask

   function automatic logic [3:0] m_pend_vec();
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = m_pend[i];
      return p;
   endfunction

   vec_t tbl [19];

   initial begin
      rst          = 1'b1;
      core_valid   = '0;
      core_success = '0;
      core_nonce   = '0;
      buf_full     = 1'b0;

      //                cv      cs    core val bf ev  en  ep      ed ef
      tbl[0]  = mk(4'b0100, 4'b0100, 2, 25, 0, 0,  0, 4'b0100, 0, 0);
      tbl[1]  = mk(4'b0000, 4'b0000, 0,  0, 0, 1, 25, 4'b0000, 0, 0);
      tbl[2]  = mk(4'b0000, 4'b0000, 0,  0, 0, 0, 25, 4'b0000, 0, 0);
      tbl[3]  = mk(4'b0010, 4'b0010, 1,  7, 1, 0, 25, 4'b0010, 0, 0);
      tbl[4]  = mk(4'b0000, 4'b0000, 0,  0, 1, 0, 25, 4'b0010, 0, 0);
      tbl[5]  = mk(4'b0000, 4'b0000, 0,  0, 1, 0, 25, 4'b0010, 0, 0);
      tbl[6]  = mk(4'b0000, 4'b0000, 0,  0, 1, 0, 25, 4'b0010, 0, 0);
      tbl[7]  = mk(4'b0000, 4'b0000, 0,  0, 1, 0, 25, 4'b0010, 0, 0);
      tbl[8]  = mk(4'b0000, 4'b0000, 0,  0, 0, 1,  7, 4'b0000, 0, 0);
      tbl[9]  = mk(4'b1000, 4'b1000, 3,  5, 1, 0,  7, 4'b1000, 0, 0);
      tbl[10] = mk(4'b1000, 4'b1000, 3,  6, 1, 0,  7, 4'b1000, 1, 1);
      tbl[11] = mk(4'b0000, 4'b0000, 0,  0, 0, 1,  5, 4'b0000, 1, 1);
      tbl[12] = mk(4'b0000, 4'b0000, 0,  0, 0, 0,  5, 4'b0000, 1, 1);
      tbl[13] = mk(4'b0001, 4'b0000, 0, 99, 0, 0,  5, 4'b0000, 1, 1);
      tbl[14] = mk(4'b0000, 4'b0000, 0,  0, 0, 0,  5, 4'b0000, 1, 1);
      tbl[15] = mk(4'b0001, 4'b0001, 0, 40, 1, 0,  5, 4'b0001, 1, 1);
      tbl[16] = mk(4'b0001, 4'b0001, 0, 41, 0, 1, 40, 4'b0001, 1, 1);
      tbl[17] = mk(4'b0000, 4'b0000, 0,  0, 0, 1, 41, 4'b0000, 1, 1);
      tbl[18] = mk(4'b0000, 4'b0000, 0,  0, 0, 0, 41, 4'b0000, 1, 1);

      do_reset();
      chk("reset_valid", 128'(valid), 128'(0));
      chk("reset_success", 128'(success), 128'(0));
      chk("reset_nonce", 128'(nonce_o), 128'(0));
      chk("reset_pending", 128'(pending), 128'(0));
      chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));
      chk("reset_drop_flag", 128'(drop_flag), 128'(0));

      for (int r = 0; r < 19; r++) begin
         step(tbl[r].cv, tbl[r].cs, tbl[r].cn, tbl[r].bf);
         chk($sformatf("tbl%0d_valid", r), 128'(valid), 128'(tbl[r].ev));
         chk($sformatf("tbl%0d_success", r), 128'(success), 128'(tbl[r].ev));
         chk($sformatf("tbl%0d_nonce", r), 128'(nonce_o), 128'(tbl[r].en));
         chk($sformatf("tbl%0d_pending", r), 128'(pending), 128'(tbl[r].ep));
         chk($sformatf("tbl%0d_drop_cnt", r), 128'(drop_cnt), 128'(tbl[r].ed));
         chk($sformatf("tbl%0d_drop_flag", r), 128'(drop_flag), 128'(tbl[r].ef));
      end

      // Simultaneous bursts drain in round-robin order starting from core 0.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         logic [31:0] base;
         base = (b == 0) ? 32'd10 : 32'd20;
         step(4'hF, 4'hF, pk(base, base + 1, base + 2, base + 3), 1'b0);
         chk($sformatf("burst%0d_capture_valid", b), 128'(valid), 128'(0));
         chk($sformatf("burst%0d_capture_pending", b), 128'(pending), 128'(4'hF));
         for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            chk($sformatf("burst%0d_k%0d_valid", b, k), 128'(valid), 128'(1));
            chk($sformatf("burst%0d_k%0d_nonce", b, k), 128'(nonce_o), 128'(base + 32'(k)));
`ifdef NONCE_ARB_TAG_EN
            chk($sformatf("burst%0d_k%0d_core_id", b, k), 128'(core_id_o), 128'(k));
`endif
         end
         idle(1'b0);
         chk($sformatf("burst%0d_done_valid", b), 128'(valid), 128'(0));
         chk($sformatf("burst%0d_done_pending", b), 128'(pending), 128'(0));
      end

      // Four drops per cycle while full, saturating at all-ones.
      do_reset();
      step(4'hF, 4'hF, pk(1, 2, 3, 4), 1'b1);
      chk("sat_load_pending", 128'(pending), 128'(4'hF));
      chk("sat_load_drop", 128'(drop_cnt), 128'(0));
      step(4'hF, 4'hF, pk(5, 6, 7, 8), 1'b1);
      chk("sat_multi_drop", 128'(drop_cnt), 128'(4));
      chk("sat_multi_flag", 128'(drop_flag), 128'(1));
      for (int k = 0; k < 74; k++) step(4'hF, 4'hF, pk(5, 6, 7, 8), 1'b1);
      chk("sat_drop_cnt", 128'(drop_cnt), 128'(255));
      chk("sat_no_valid", 128'(valid), 128'(0));
      idle(1'b0);
      chk("sat_release_valid", 128'(valid), 128'(1));
      chk("sat_release_nonce", 128'(nonce_o), 128'(1));

      // Reset while slots are pending and an output is in flight.
      rst = 1'b1;
      step(4'hF, 4'hF, pk(9, 9, 9, 9), 1'b0);
      rst = 1'b0;
      chk("rst_mid_valid", 128'(valid), 128'(0));
      chk("rst_mid_success", 128'(success), 128'(0));
      chk("rst_mid_nonce", 128'(nonce_o), 128'(0));
      chk("rst_mid_pending", 128'(pending), 128'(0));
      chk("rst_mid_drop_cnt", 128'(drop_cnt), 128'(0));
      chk("rst_mid_drop_flag", 128'(drop_flag), 128'(0));
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            idle(1'b0);
            if (valid) seen++;
         end
         chk("rst_mid_no_valid_after", 128'(seen), 128'(0));
      end

      // Randomized traffic against the reference model, two densities.
      for (int rnd = 0; rnd < 2; rnd++) begin
         do_reset();
         model_reset();
         for (int c = 0; c < 600; c++) begin
            logic [3:0]   cv;
            logic [3:0]   cs;
            logic [127:0] cn;
            logic         bf;
            cv = (rnd == 0) ? 4'($urandom & $urandom & $urandom) : 4'($urandom & $urandom);
            cs = 4'($urandom | $urandom);
            cn = {$urandom, $urandom, $urandom, $urandom};
            bf = ($urandom_range(0, 3) == 0);
            model_cycle(cv, cs, cn, bf);
            step(cv, cs, cn, bf);
            chk($sformatf("rand%0d_c%0d_valid", rnd, c), 128'(valid), 128'(m_valid));
            chk($sformatf("rand%0d_c%0d_success", rnd, c), 128'(success), 128'(m_valid));
            chk($sformatf("rand%0d_c%0d_nonce", rnd, c), 128'(nonce_o), 128'(m_nonce));
            chk($sformatf("rand%0d_c%0d_pending", rnd, c), 128'(pending), 128'(m_pend_vec()));
            chk($sformatf("rand%0d_c%0d_drop_cnt", rnd, c), 128'(drop_cnt), 128'(m_drop));
            chk($sformatf("rand%0d_c%0d_drop_flag", rnd, c), 128'(drop_flag), 128'(m_flag));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
